ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_kbd_pkg.sv | 62 ++++++
 rtl/ps2_frame_rx.sv | 107 ++++++++++
 rtl/ps2_keyboard_rx.sv | 70 +++++++
 tb/tb_ps2_keyboard_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// scan codes of interest and the key-to-bit lookup used by the decoder.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Arrow keys only match with the E0 prefix; the rest only without it.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t res;
    res.hit = 1'b1;
    res.idx = '0;
    if (ext) begin
      case (code)
        SC_UP:    res.idx = KEY_UP;
        SC_DOWN:  res.idx = KEY_DOWN;
        SC_LEFT:  res.idx = KEY_LEFT;
        SC_RIGHT: res.idx = KEY_RIGHT;
        default:  res.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_SPACE: res.idx = KEY_SPACE;
        SC_ENTER: res.idx = KEY_ENTER;
        SC_ESC:   res.idx = KEY_ESC;
        SC_P:     res.idx = KEY_P;
        default:  res.hit = 1'b0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronizers, PS/2 clock glitch filter, 11-bit frame FSM
// and inter-edge timeout. Strobes are single-cycle and registered by the parent.
module ps2_frame_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  frame_state_e  r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_ok;
  logic [TW-1:0] r_to_cnt;

  logic w_disagree, w_flip, w_fall, w_timeout, w_stop_good;

  assign w_disagree  = (r_clk_sync != r_filt);
  assign w_flip      = w_disagree && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_fall      = w_flip && r_filt;
  // An edge in the same cycle as the last timeout count wins.
  assign w_timeout   = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_good = r_dat_sync && r_par_ok;

  assign o_byte     = r_shift;
  assign o_byte_stb = w_fall && (r_state == ST_STOP) && w_stop_good;
  assign o_err      = w_timeout ||
                      (w_fall && (r_state == ST_IDLE) && r_dat_sync) ||
                      (w_fall && (r_state == ST_STOP) && !w_stop_good);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_dat;
      r_dat_sync <= r_dat_meta;
      if (!w_disagree) begin
        r_filt_cnt <= '0;
      end else if (w_flip) begin
        r_filt     <= ~r_filt;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_ok  <= 1'b0;
      r_to_cnt  <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_sync) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          r_shift   <= {r_dat_sync, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
        end
        ST_PARITY: begin
          r_par_ok <= ^{r_shift, r_dat_sync};
          r_state  <= ST_STOP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
    end else begin
      if (w_timeout) r_state <= ST_IDLE;
      if (r_to_cnt != TW'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame reception plus E0/F0 prefix decoding into
// an 8-bit held-key vector. All outputs are registered.
module ps2_keyboard_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_state,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_stb, w_err;
  key_hit_t   w_hit;
  logic       r_ext, r_brk;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_ps2_clk (ps2_clk),
    .i_ps2_dat (ps2_dat),
    .o_byte    (w_byte),
    .o_byte_stb(w_byte_stb),
    .o_err     (w_err)
  );

  assign w_hit = key_lookup(w_byte, r_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_state  <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= w_err;
      if (w_err) begin
        // A broken frame may have been the key code a prefix was waiting for.
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_stb) begin
        scan_code  <= w_byte;
        scan_valid <= 1'b1;
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          if (w_hit.hit) key_state[w_hit.idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus pushes expected events, a
// negedge monitor pops and compares on every scan_valid / frame_err strobe.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_state, scan_code;
  logic       scan_valid, frame_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .key_state (key_state),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_SCAN, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  code;
    logic [7:0]  keys;
    bit          timed;
    int unsigned at_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input ev_kind_e k);
    exp_t e;
    check(k == EV_SCAN ? "sb_expect_scan" : "sb_expect_err", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("event_kind", 32'(e.kind), 32'(k));
    if (k == EV_SCAN) begin
      check("scan_code", 32'(scan_code), 32'(e.code));
      check("key_state", 32'(key_state), 32'(e.keys));
    end
    if (e.timed) check("timeout_cycle", cyc, e.at_cyc);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_valid) expect_event(EV_SCAN);
      if (frame_err)  expect_event(EV_ERR);
    end
  end

  task automatic push_scan(input logic [7:0] c, input logic [7:0] k);
    exp_t e;
    e.kind = EV_SCAN; e.code = c; e.keys = k; e.timed = 1'b0; e.at_cyc = 0;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input bit timed, input int unsigned at);
    exp_t e;
    e.kind = EV_ERR; e.code = '0; e.keys = '0; e.timed = timed; e.at_cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    repeat (HALF) @(posedge clk);
    #1 ps2_dat = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic tx(input logic [7:0] b, input logic [7:0] keys_after);
    push_scan(b, keys_after);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_state"},  32'(key_state),  32'd0);
    check({tag, "_scan_code"},  32'(scan_code),  32'd0);
    check({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
    check({tag, "_frame_err"},  32'(frame_err),  32'd0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);

    // Plain make, unprefixed arrow code, extended make and extended break.
    tx(8'h75, 8'h00);
    tx(8'h29, 8'h10);
    tx(8'hE0, 8'h10);
    tx(8'h75, 8'h11);
    tx(8'hE0, 8'h11);
    tx(8'hF0, 8'h11);
    tx(8'h75, 8'h10);
    tx(8'hF0, 8'h10);
    tx(8'h29, 8'h00);

    // Parity error drops the byte; the retry registers enter; repeat is harmless.
    push_err(1'b0, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    tx(8'h5A, 8'h20);
    tx(8'h5A, 8'h20);

    // Start-bit error clears a pending E0, so a bare 75 maps to nothing.
    tx(8'hE0, 8'h20);
    push_err(1'b0, 0);
    ps2_bit(1'b1);
    repeat (10) @(posedge clk);
    tx(8'h75, 8'h20);

    // Stop-bit error, then P and the remaining extended arrows.
    push_err(1'b0, 0);
    send_frame(8'h4D, 1'b0, 1'b0);
    tx(8'h4D, 8'hA0);
    tx(8'hE0, 8'hA0);
    tx(8'h72, 8'hA2);
    tx(8'hE0, 8'hA2);
    tx(8'h6B, 8'hA6);
    tx(8'hE0, 8'hA6);
    tx(8'h74, 8'hAE);

    // Short low glitch on the clock pin must not be seen as an edge.
    @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (40) @(posedge clk);

    // Frame cut after 4 data bits: error exactly 2 + FILTER_LEN + TIMEOUT after the last pin fall.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_dat = 1'b1;
    push_err(1'b1, last_fall + 2 + FILTER_LEN + TIMEOUT);
    repeat (TIMEOUT + 50) @(posedge clk);
    tx(8'h76, 8'hEE);

    // Reset in the middle of a frame abandons it silently.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    #3 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2 * TIMEOUT) @(posedge clk);
    check("after_reset_no_events", 32'(sb_q.size()), 32'd0);
    tx(8'h29, 8'h10);

    repeat (50) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
